// File: rtl/membus_pkg.sv
// rtl/membus_pkg.sv - shared state encoding and beat helpers for the memory bus bridge
package membus_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  function automatic int beat_count(input int addr_w, input int pin_w);
    return (addr_w + pin_w - 1) / pin_w;
  endfunction

  function automatic int asel_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Beat idx of a zero-padded address, right-aligned in a 64-bit word.
  function automatic logic [63:0] beat_slice(input logic [63:0] addr, input int idx,
                                             input int pin_w);
    logic [63:0] mask;
    mask = (64'd1 << pin_w) - 64'd1;
    return (addr >> (idx * pin_w)) & mask;
  endfunction

endpackage

// File: rtl/membus_beat_sel.sv
// rtl/membus_beat_sel.sv - picks the next address beat to present (MS first)
// MEMBUS_ACACHE_EN: skip beats that already match the cached latched address.
module membus_beat_sel
  import membus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int PIN_W = 4,
  localparam int ADDR_BEATS = beat_count(ADDR_W, PIN_W),
  localparam int ASEL_W = asel_width(ADDR_BEATS)
) (
  input  logic              start,
  input  logic [ASEL_W-1:0] cur,
`ifdef MEMBUS_ACACHE_EN
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_valid,
`endif
  output logic [ASEL_W-1:0] beat,
  output logic              found
);

`ifdef MEMBUS_ACACHE_EN
  // Highest-index differing beat below cur (or below ADDR_BEATS on start).
  always_comb begin
    beat = '0;
    found = 1'b0;
    for (int b = 0; b < ADDR_BEATS; b++) begin
      if ((start || (ASEL_W'(b) < cur)) &&
          (!cache_valid ||
           beat_slice(64'(addr), b, PIN_W) != beat_slice(64'(cache_addr), b, PIN_W))) begin
        beat = ASEL_W'(b);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    beat = start ? ASEL_W'(ADDR_BEATS - 1) : cur - ASEL_W'(1);
    found = start || (cur != '0);
  end
`endif

endmodule

// File: rtl/membus_bridge.sv
// rtl/membus_bridge.sv - CPU request port to pin-multiplexed external SRAM bus bridge
// MEMBUS_ACACHE_EN: enables the last-latched-address cache that skips unchanged beats.
module membus_bridge
  import membus_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int PIN_W = 4,
  parameter int ADDR_W = 8,
  parameter int WAIT_STATES = 0,
  localparam int ADDR_BEATS = beat_count(ADDR_W, PIN_W),
  localparam int ASEL_W = asel_width(ADDR_BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [PIN_W-1:0]  bus_out,
  output logic              bus_oe,
  output logic              bus_alat,
  output logic [ASEL_W-1:0] bus_asel,
  output logic              bus_we_n,
  output logic              bus_strobe_n,
  input  logic [DATA_W-1:0] bus_in
);

  localparam int PAD_W = ADDR_BEATS * PIN_W;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;

  logic              accept;
  logic              in_idle;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic [DATA_W-1:0] cur_wdata;
  logic [PAD_W-1:0]  addr_pad;
  logic [PIN_W-1:0]  beat_word;
  logic [ASEL_W-1:0] sel_beat;
  logic              sel_found;

  // In IDLE the request inputs are used directly so the first beat goes out on accept.
  assign in_idle   = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign cur_addr  = in_idle ? req_addr : addr_q;
  assign cur_we    = in_idle ? req_we : we_q;
  assign cur_wdata = in_idle ? req_wdata : wdata_q;
  assign addr_pad  = PAD_W'(cur_addr);

  always_comb begin
    beat_word = '0;
    for (int b = 0; b < ADDR_BEATS; b++) begin
      if (sel_beat == ASEL_W'(b)) beat_word = addr_pad[b*PIN_W +: PIN_W];
    end
  end

`ifdef MEMBUS_ACACHE_EN
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_valid;
`endif

  membus_beat_sel #(
    .ADDR_W(ADDR_W),
    .PIN_W (PIN_W)
  ) u_beat_sel (
    .start      (in_idle),
    .cur        (bus_asel),
`ifdef MEMBUS_ACACHE_EN
    .addr       (cur_addr),
    .cache_addr (cache_addr),
    .cache_valid(cache_valid),
`endif
    .beat       (sel_beat),
    .found      (sel_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wait_cnt     <= '0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      bus_out      <= '0;
      bus_oe       <= 1'b0;
      bus_alat     <= 1'b0;
      bus_asel     <= '0;
      bus_we_n     <= 1'b1;
      bus_strobe_n <= 1'b1;
`ifdef MEMBUS_ACACHE_EN
      cache_addr   <= '0;
      cache_valid  <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (state == ST_DATA) begin
        if (wait_cnt == 4'd0) begin
          state        <= ST_IDLE;
          req_ready    <= 1'b1;
          rsp_valid    <= 1'b1;
          if (!we_q) rsp_rdata <= bus_in;
          bus_oe       <= 1'b0;
          bus_out      <= '0;
          bus_we_n     <= 1'b1;
          bus_strobe_n <= 1'b1;
        end else begin
          wait_cnt     <= wait_cnt - 4'd1;
          bus_strobe_n <= (wait_cnt != 4'd1);
        end
      end else if (state == ST_ADDR || accept) begin
        if (in_idle) begin
          addr_q    <= req_addr;
          we_q      <= req_we;
          wdata_q   <= req_wdata;
          req_ready <= 1'b0;
        end
        if (sel_found) begin
          state    <= ST_ADDR;
          bus_alat <= 1'b1;
          bus_oe   <= 1'b1;
          bus_asel <= sel_beat;
          bus_out  <= beat_word;
        end else begin
          // Address fully latched externally: start the data phase.
          state        <= ST_DATA;
          bus_alat     <= 1'b0;
          bus_asel     <= '0;
          bus_oe       <= cur_we;
          bus_out      <= cur_we ? PIN_W'(cur_wdata) : '0;
          bus_we_n     <= !cur_we;
          bus_strobe_n <= (WAIT_STATES != 0);
          wait_cnt     <= 4'(WAIT_STATES);
`ifdef MEMBUS_ACACHE_EN
          cache_addr   <= cur_addr;
          cache_valid  <= 1'b1;
`endif
        end
      end
    end
  end

endmodule
